// File: rtl/down_timer.sv
// Programmable count-down timer with prescaler, one-shot/periodic modes,
// a one-cycle timeout pulse and a sticky interrupt flag.
module down_timer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load,
  input  logic [PRE_W-1:0] prescale,
  input  logic             irq_clear,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             timeout,
  output logic             irq
);

  typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);
  localparam logic [PRE_W-1:0] PreOne   = PRE_W'(1);

  state_e           state_q;
  logic [WIDTH-1:0] load_q;
  logic [PRE_W-1:0] pre_q;
  logic             periodic_q;
  logic [PRE_W-1:0] pre_cnt_q;
  logic             start_ok;

  assign start_ok = start && !stop && (load != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      load_q     <= '0;
      pre_q      <= '0;
      periodic_q <= 1'b0;
      pre_cnt_q  <= '0;
      count      <= '0;
      running    <= 1'b0;
      timeout    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      timeout <= 1'b0;
      // A coincident expiry below overrides this clear.
      if (irq_clear) irq <= 1'b0;

      if (start_ok) begin
        load_q     <= load;
        pre_q      <= prescale;
        periodic_q <= periodic;
        count      <= load;
        pre_cnt_q  <= '0;
        state_q    <= StRun;
        running    <= 1'b1;
      end else if (state_q == StRun) begin
        if (stop) begin
          // Freeze the count; any tick due this edge is dropped.
          state_q   <= StIdle;
          running   <= 1'b0;
          pre_cnt_q <= '0;
        end else if (pre_cnt_q == pre_q) begin
          pre_cnt_q <= '0;
          if (count > CountOne) begin
            count <= count - CountOne;
          end else begin
            timeout <= 1'b1;
            irq     <= 1'b1;
            if (periodic_q) begin
              count <= load_q;
            end else begin
              count   <= '0;
              state_q <= StExpired;
              running <= 1'b0;
            end
          end
        end else begin
          pre_cnt_q <= pre_cnt_q + PreOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer; expected values are hand-derived.
module tb_down_timer;

  logic        clk = 1'b0;
  logic        rst, start, stop, periodic, irq_clear;
  logic [15:0] load, prescale;
  logic [15:0] count;
  logic        running, timeout, irq;

  int checks = 0;
  int errors = 0;

  down_timer #(.WIDTH(16), .PRE_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .load      (load),
    .prescale  (prescale),
    .irq_clear (irq_clear),
    .count     (count),
    .running   (running),
    .timeout   (timeout),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] c, input logic r,
                         input logic t, input logic i);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".running"}, 32'(running), 32'(r));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    chk({tag, ".irq"}, 32'(irq), 32'(i));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0; irq_clear = 1'b0;
    load = '0; prescale = '0;
    cyc(2);
    chk_all("reset", 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // One-shot, load 5, prescale 0.
    load = 16'd5; prescale = 16'd0; periodic = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("os_start", 16'd5, 1'b1, 1'b0, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      cyc(1);
      chk_all("os_run", 16'(k), 1'b1, 1'b0, 1'b0);
    end
    cyc(1);
    chk_all("os_expire", 16'd0, 1'b0, 1'b1, 1'b1);
    cyc(2);
    chk_all("os_hold", 16'd0, 1'b0, 1'b0, 1'b1);
    irq_clear = 1'b1;
    cyc(1);
    irq_clear = 1'b0;
    chk("irq_clear", 32'(irq), 32'd0);

    // Periodic, load 3, prescale 1: period 6 cycles.
    load = 16'd3; prescale = 16'd1; periodic = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    load = 16'd9; prescale = 16'd0; periodic = 1'b0;
    chk("per_start", 32'(count), 32'd3);
    for (int c = 1; c <= 24; c++) begin
      cyc(1);
      chk("per_count", 32'(count), 32'(3 - ((c % 6) / 2)));
      chk("per_timeout", 32'(timeout), 32'((c % 6) == 0));
      chk("per_running", 32'(running), 32'd1);
    end

    // Restart load 10 with irq clear, then stop at 6.
    load = 16'd10; prescale = 16'd0; periodic = 1'b0; start = 1'b1; irq_clear = 1'b1;
    cyc(1);
    start = 1'b0; irq_clear = 1'b0;
    chk_all("restart10", 16'd10, 1'b1, 1'b0, 1'b0);
    cyc(4);
    chk("cnt6", 32'(count), 32'd6);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk_all("stopped", 16'd6, 1'b0, 1'b0, 1'b0);
    cyc(3);
    chk_all("frozen", 16'd6, 1'b0, 1'b0, 1'b0);
    load = 16'd2; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("l2_start", 16'd2, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_all("l2_one", 16'd1, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_all("l2_expire", 16'd0, 1'b0, 1'b1, 1'b1);

    // Park in IDLE at 8, then load-0 start is ignored.
    load = 16'd8; start = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk_all("idle8", 16'd8, 1'b0, 1'b0, 1'b1);
    load = 16'd0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("load0", 16'd8, 1'b0, 1'b0, 1'b1);

    // Restart with load 4 while running at count 2.
    load = 16'd6; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    chk("cnt2", 32'(count), 32'd2);
    load = 16'd4; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk_all("rs4", 16'd4, 1'b1, 1'b0, 1'b1);
    cyc(3);
    chk_all("rs4_one", 16'd1, 1'b1, 1'b0, 1'b1);
    cyc(1);
    chk_all("rs4_expire", 16'd0, 1'b0, 1'b1, 1'b1);

    // irq_clear held across an expiry: set wins, then clears.
    load = 16'd2; start = 1'b1;
    cyc(1);
    start = 1'b0; irq_clear = 1'b1;
    cyc(1);
    chk("clr_pre", 32'(irq), 32'd0);
    cyc(1);
    chk_all("clr_exp", 16'd0, 1'b0, 1'b1, 1'b1);
    cyc(1);
    irq_clear = 1'b0;
    chk("clr_post", 32'(irq), 32'd0);

    // Stop on the expiry edge suppresses the expiry.
    load = 16'd3; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    chk("stopexp_one", 32'(count), 32'd1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk_all("stopexp", 16'd1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk_all("stopexp2", 16'd1, 1'b0, 1'b0, 1'b0);

    // Periodic load 1, prescale 0: timeout every cycle.
    load = 16'd1; periodic = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk_all("p1", 16'd1, 1'b1, 1'b1, 1'b1);
    end
    stop = 1'b1; periodic = 1'b0;
    cyc(1);
    stop = 1'b0;
    chk_all("p1_stop", 16'd1, 1'b0, 1'b0, 1'b1);

    // Reset mid-run at count 7, start held during reset.
    load = 16'd10; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    chk("cnt7", 32'(count), 32'd7);
    rst = 1'b1; start = 1'b1; load = 16'd5;
    cyc(1);
    rst = 1'b0;
    chk_all("rst_mid", 16'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    start = 1'b0;
    chk_all("post_rst", 16'd5, 1'b1, 1'b0, 1'b0);
    cyc(4);
    chk_all("post_rst_one", 16'd1, 1'b1, 1'b0, 1'b0);
    cyc(1);
    chk_all("post_rst_exp", 16'd0, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Programmable count-down timer. It complements the up-counting timer in the same SoC peripheral set.
- Loads a start value and decrements it once every (PRESCALE+1) clock cycles.
- Signals expiry with a one-cycle pulse and a sticky interrupt flag.
- Supports one-shot and periodic (auto-reload) modes.
- Intended as the timeout/interval source for the MCU bus-attached peripherals.

Parameters:
WIDTH, 16, width of load value and count
PRE_W, 16, width of prescale value

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  level-sampled start/restart request
stop  input  1  level-sampled halt request
periodic  input  1  0 = one-shot, 1 = auto-reload; sampled with start
load  input  WIDTH  initial count; sampled with start
prescale  input  PRE_W  tick divider; ticks occur every prescale+1 cycles; sampled with start
irq_clear  input  1  clears irq
count  output  WIDTH  current count value
running  output  1  1 while in RUN state
timeout  output  1  one-cycle pulse on expiry
irq  output  1  sticky expiry flag

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, count=0, running=0, timeout=0, irq=0, prescale counter=0, latched load/prescale/periodic=0. Reset overrides every other input, including mid-run.
- States: IDLE, RUN, EXPIRED. running=1 only in RUN.
- Start acceptance (any state, stop=0, start=1, load!=0) at edge E0:
  - latch load/prescale/periodic;
  - count<=load, pre_cnt<=0, state<=RUN.
- start with load==0 is ignored; state and count are unchanged.
- start in RUN is a restart: reload from the new inputs, pre_cnt<=0, no timeout generated.
- RUN, each edge:
  - if pre_cnt==latched prescale, then pre_cnt<=0 and tick=1;
  - else pre_cnt<=pre_cnt+1.
- On tick with count>1: count<=count-1.
- On tick with count==1 (expiry): timeout<=1 for exactly one cycle, irq<=1, and then:
  - one-shot: count<=0, state<=EXPIRED;
  - periodic: count<=latched load, state stays RUN, pre_cnt restarts from 0.
- Expiry timing: first expiry at edge E0 + load*(prescale+1). Periodic expiries repeat every load*(prescale+1) cycles.
- Changes to load/prescale/periodic while in RUN have no effect until the next accepted start.
- stop=1 in RUN: state<=IDLE, count holds its value, pre_cnt<=0, no tick processed that edge.
  - stop has priority over start and over a coincident tick/expiry; no timeout is produced.
- stop in IDLE or EXPIRED: no effect.
- EXPIRED: count=0, running=0, waits for start. IDLE after stop holds the frozen count until start.
- irq: set on expiry, cleared by irq_clear. Set wins if both occur at the same edge. irq_clear with no expiry clears at the next edge.
- timeout is a registered output: high in the cycle following the expiry edge only, never two consecutive cycles unless load=1 and prescale=0 in periodic mode (then high every cycle).
- Arithmetic: count never wraps below 0; pre_cnt compares equal to prescale, and prescale=0 gives a tick every cycle. Maximum interval is (2^WIDTH-1)*2^PRE_W cycles.

Test Plan:
- Reset, then load=5, prescale=0, periodic=0, 1-cycle start.
  - Required: count 5,4,3,2,1,0 on consecutive cycles.
  - timeout high exactly once, 5 cycles after the start edge; irq=1; running=0; state EXPIRED; count stays 0.
- load=3, prescale=1, periodic=1.
  - Required: count holds each value 2 cycles (3,3,2,2,1,1,3,...).
  - timeout pulses every 6 cycles for at least 4 periods; running stays 1.
- load=10, prescale=0, stop asserted at count=6 for 1 cycle.
  - Required: count frozen at 6, running=0, no timeout.
  - Then start with load=2 gives timeout 2 cycles later.
- start with load=0 in IDLE: count, running, irq unchanged.
  - start with load=4 while RUN at count=2: count=4 on the next edge, expiry 4 cycles later.
- Coincident events:
  - irq_clear held high across an expiry edge: irq=1 after that edge, irq=0 one cycle after irq_clear remains asserted.
  - stop asserted on the expiry edge: no timeout, irq stays 0.
- Reset mid-run: assert rst for 1 cycle during RUN with count=7.
  - Required: all outputs 0 on the next edge.
  - start held high during rst is ignored; timer runs normally on the next start after rst deasserts.
